alu_arbiter: RTL and testbench

Shares the single `alu` execution unit of the RV32I core between two requesters (0: execute stage, 1: address/branch-compare helper). Arbitrates round-robin, drives the ALU command for at most one op per cycle, tracks in-flight ops in a tag pipeline matched to the ALU latency, and routes each registered result back to its issuer. Unsupported `funct3`/`funct7` encodings are screened out, and the ALU is not enabled for them.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_tag_pipe.sv | 33 +++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU encoding constants, tag type and legality check
//
// Purpose : constants and types shared by the ALU arbiter and its tag pipeline.
// Contents: FUNCT7_BASE / FUNCT7_ALT, FUNCT3_ADD_SUB / FUNCT3_SRL_SRA,
//           alu_tag_t {valid, id, illegal}, is_legal(funct3, funct7).
package alu_pkg;

  localparam logic [6:0] FUNCT7_BASE    = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT     = 7'b0100000;
  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

  typedef struct packed {
    logic valid;
    logic id;
    logic illegal;
  } alu_tag_t;

  // Only SUB and SRA use the alternate funct7; everything else must be base.
  function automatic logic is_legal(input logic [2:0] funct3, input logic [6:0] funct7);
    return (funct7 == FUNCT7_BASE) ||
           ((funct7 == FUNCT7_ALT) &&
            ((funct3 == FUNCT3_ADD_SUB) || (funct3 == FUNCT3_SRL_SRA)));
  endfunction

endpackage

// File: rtl/alu_tag_pipe.sv
// rtl/alu_tag_pipe.sv - fixed-depth shift register of in-flight ALU op tags
//
// Purpose : carries {valid, id, illegal} alongside an op while the ALU works on it.
// Ports   : clock, reset_n (async, active low), clear (sync, drops every tag),
//           tag_in (loaded into stage 0 each cycle), tag_out (last stage).
module alu_tag_pipe
  import alu_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     clear,
  input  alu_tag_t tag_in,
  output alu_tag_t tag_out
);

  alu_tag_t r_stage [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign tag_out = r_stage[DEPTH-1];

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
//
// Purpose : grants one of two requesters per cycle, screens illegal encodings,
//           drives the ALU command and routes the registered result back.
// Ports   : clock, reset_n (async, active low), flush;
//           req_valid/req_ready[1:0], req_funct3_k, req_funct7_k,
//           req_operand_{0,1}_k (k = requester);
//           rsp_valid/rsp_error[1:0], rsp_data_0/1 (registered);
//           alu_enable, alu_funct3, alu_funct7, alu_operand_0/1 (combinational),
//           alu_destination (ALU result, ALU_LATENCY cycles after enable).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [2:0]  req_funct3_0,
  input  logic [2:0]  req_funct3_1,
  input  logic [6:0]  req_funct7_0,
  input  logic [6:0]  req_funct7_1,
  input  logic [31:0] req_operand_0_0,
  input  logic [31:0] req_operand_1_0,
  input  logic [31:0] req_operand_0_1,
  input  logic [31:0] req_operand_1_1,
  output logic [1:0]  rsp_valid,
  output logic [1:0]  rsp_error,
  output logic [31:0] rsp_data_0,
  output logic [31:0] rsp_data_1,
  output logic        alu_enable,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] alu_operand_0,
  output logic [31:0] alu_operand_1,
  input  logic [31:0] alu_destination
);

  logic        r_rr_ptr;
  logic [1:0]  r_rsp_valid;
  logic [1:0]  r_rsp_error;
  logic [31:0] r_rsp_data_0;
  logic [31:0] r_rsp_data_1;

  logic        w_grant;
  logic        w_xfer;
  logic        w_legal;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_operand_0;
  logic [31:0] w_operand_1;
  alu_tag_t    w_tag_in;
  alu_tag_t    w_tag_last;

  // Contention goes to rr_ptr; otherwise whichever requester is valid.
  assign w_grant = (req_valid == 2'b11) ? r_rr_ptr : req_valid[1];
  // reset_n gating keeps req_ready/alu_enable low while held in reset.
  assign w_xfer    = reset_n & ~flush & (|req_valid);
  assign req_ready = {w_xfer & w_grant, w_xfer & ~w_grant};

  assign w_funct3    = w_grant ? req_funct3_1    : req_funct3_0;
  assign w_funct7    = w_grant ? req_funct7_1    : req_funct7_0;
  assign w_operand_0 = w_grant ? req_operand_0_1 : req_operand_0_0;
  assign w_operand_1 = w_grant ? req_operand_1_1 : req_operand_1_0;
  assign w_legal     = is_legal(w_funct3, w_funct7);

  assign alu_enable    = w_xfer & w_legal;
  assign alu_funct3    = alu_enable ? w_funct3    : '0;
  assign alu_funct7    = alu_enable ? w_funct7    : '0;
  assign alu_operand_0 = alu_enable ? w_operand_0 : '0;
  assign alu_operand_1 = alu_enable ? w_operand_1 : '0;

  always_comb begin
    w_tag_in         = '0;
    w_tag_in.valid   = w_xfer;
    w_tag_in.id      = w_grant;
    w_tag_in.illegal = ~w_legal;
  end

  // The response register below acts as the final tag stage, so the shift
  // register only needs ALU_LATENCY entries to line up with alu_destination.
  alu_tag_pipe #(
    .DEPTH (ALU_LATENCY)
  ) u_tag_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (flush),
    .tag_in  (w_tag_in),
    .tag_out (w_tag_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_xfer) begin
      r_rr_ptr <= ~w_grant;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid  <= '0;
      r_rsp_error  <= '0;
      r_rsp_data_0 <= '0;
      r_rsp_data_1 <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_error <= '0;
      if (!flush && w_tag_last.valid) begin
        r_rsp_valid[w_tag_last.id] <= 1'b1;
        r_rsp_error[w_tag_last.id] <= w_tag_last.illegal;
        if (w_tag_last.id) begin
          r_rsp_data_1 <= w_tag_last.illegal ? '0 : alu_destination;
        end else begin
          r_rsp_data_0 <= w_tag_last.illegal ? '0 : alu_destination;
        end
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_error  = r_rsp_error;
  assign rsp_data_0 = r_rsp_data_0;
  assign rsp_data_1 = r_rsp_data_1;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter at ALU_LATENCY 1 and 3
module tb_alu_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [2:0]  f3_0 = '0, f3_1 = '0;
  logic [6:0]  f7_0 = '0, f7_1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic [1:0]  rdy_a, rv_a, re_a, rdy_b, rv_b, re_b;
  logic [31:0] d0_a, d1_a, d0_b, d1_b;
  logic        en_a, en_b;
  logic [2:0]  af3_a, af3_b;
  logic [6:0]  af7_a, af7_b;
  logic [31:0] op0_a, op1_a, op0_b, op1_b;
  logic [31:0] dest_a, dest_b;
  logic [31:0] pa [4];
  logic [31:0] pb [4];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int          id;
    int          err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_arbiter #(.ALU_LATENCY(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(rdy_a),
    .req_funct3_0(f3_0), .req_funct3_1(f3_1),
    .req_funct7_0(f7_0), .req_funct7_1(f7_1),
    .req_operand_0_0(a0), .req_operand_1_0(b0),
    .req_operand_0_1(a1), .req_operand_1_1(b1),
    .rsp_valid(rv_a), .rsp_error(re_a), .rsp_data_0(d0_a), .rsp_data_1(d1_a),
    .alu_enable(en_a), .alu_funct3(af3_a), .alu_funct7(af7_a),
    .alu_operand_0(op0_a), .alu_operand_1(op1_a), .alu_destination(dest_a)
  );

  alu_arbiter #(.ALU_LATENCY(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(rdy_b),
    .req_funct3_0(f3_0), .req_funct3_1(f3_1),
    .req_funct7_0(f7_0), .req_funct7_1(f7_1),
    .req_operand_0_0(a0), .req_operand_1_0(b0),
    .req_operand_0_1(a1), .req_operand_1_1(b1),
    .rsp_valid(rv_b), .rsp_error(re_b), .rsp_data_0(d0_b), .rsp_data_1(d1_b),
    .alu_enable(en_b), .alu_funct3(af3_b), .alu_funct7(af7_b),
    .alu_operand_0(op0_b), .alu_operand_1(op1_b), .alu_destination(dest_b)
  );

  // Reference RV32I ALU behind a latency pipe.
  function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0: return f7[5] ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return f7[5] ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  always @(posedge clock) begin
    pa[0] <= alu_fn(af3_a, af7_a, op0_a, op1_a);
    pb[0] <= alu_fn(af3_b, af7_b, op0_b, op1_b);
    for (int i = 1; i < 4; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  assign dest_a = pa[0];
  assign dest_b = pb[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic purge(input int lim, input bit inclusive);
    for (int i = qa.size() - 1; i >= 0; i--)
      if (qa[i].due > lim || (inclusive && qa[i].due == lim)) qa.delete(i);
    for (int i = qb.size() - 1; i >= 0; i--)
      if (qb[i].due > lim || (inclusive && qb[i].due == lim)) qb.delete(i);
  endtask

  task automatic set0(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] x, input logic [31:0] y);
    f3_0 = f3; f7_0 = f7; a0 = x; b0 = y;
  endtask

  task automatic set1(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] x, input logic [31:0] y);
    f3_1 = f3; f7_1 = f7; a1 = x; b1 = y;
  endtask

  // Called just after a rising edge: drives one cycle, checks the combinational
  // side mid-cycle, pushes expected responses, returns just after the next edge.
  task automatic step(input logic [1:0] v, input logic fl, input logic [1:0] er,
                      input logic ee, input logic [31:0] ed, input logic eerr);
    exp_t x;
    req_valid = v;
    flush = fl;
    @(negedge clock);
    chk("ready_a", {30'd0, rdy_a}, {30'd0, er});
    chk("ready_b", {30'd0, rdy_b}, {30'd0, er});
    chk("enable_a", {31'd0, en_a}, {31'd0, ee});
    chk("enable_b", {31'd0, en_b}, {31'd0, ee});
    if (ee) chk("alu_operand_0", op0_a, er[1] ? a1 : a0);
    if (er != 2'b00) begin
      x.id = er[1] ? 1 : 0;
      x.err = eerr ? 1 : 0;
      x.data = ed;
      x.due = cyc + 2;
      qa.push_back(x);
      x.due = cyc + 4;
      qb.push_back(x);
    end
    // Responses already registered when flush arrives stay visible.
    if (fl) purge(cyc, 1'b0);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    purge(cyc, 1'b1);
    req_valid = 2'b11;
    flush = 1'b0;
    @(negedge clock);
    chk("reset_ready_a", {30'd0, rdy_a}, 32'd0);
    chk("reset_ready_b", {30'd0, rdy_b}, 32'd0);
    chk("reset_enable_a", {31'd0, en_a}, 32'd0);
    chk("reset_enable_b", {31'd0, en_b}, 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    req_valid = 2'b00;
  endtask

  task automatic mon(input int inst, input logic [1:0] v, input logic [1:0] e,
                     input logic [31:0] d0, input logic [31:0] d1);
    exp_t x;
    int n;
    if (v != 2'b00) chk("rsp_overlap", {31'd0, v == 2'b11}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      if (v[k]) begin
        n = (inst == 0) ? qa.size() : qb.size();
        if (n == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: dut %0d requester %0d got rsp_valid want none at cycle %0d", inst, k, cyc);
        end else begin
          x = (inst == 0) ? qa.pop_front() : qb.pop_front();
          chk("rsp_id", k, x.id);
          chk("rsp_error", {31'd0, e[k]}, x.err);
          chk("rsp_data", (k == 1) ? d1 : d0, x.data);
          chk("rsp_cycle", cyc, x.due);
        end
      end
    end
    if (inst == 0 && qa.size() > 0 && qa[0].due < cyc) begin
      x = qa.pop_front();
      total++; bad++;
      $display("FAIL missing_rsp: dut 0 requester %0d got nothing want data %h by cycle %0d", x.id, x.data, x.due);
    end
    if (inst == 1 && qb.size() > 0 && qb[0].due < cyc) begin
      x = qb.pop_front();
      total++; bad++;
      $display("FAIL missing_rsp: dut 1 requester %0d got nothing want data %h by cycle %0d", x.id, x.data, x.due);
    end
  endtask

  always @(negedge clock) begin
    mon(0, rv_a, re_a, d0_a, d1_a);
    mon(1, rv_b, re_b, d0_b, d1_b);
  end

  localparam logic [6:0] F7B = 7'b0000000;
  localparam logic [6:0] F7A = 7'b0100000;

  initial begin
    // Held in reset with both requesters valid.
    req_valid = 2'b11;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk("reset_ready_a", {30'd0, rdy_a}, 32'd0);
    chk("reset_enable_b", {31'd0, en_b}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Idle after reset release.
    repeat (10) step(2'b00, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0);
    chk("idle_data_0_a", d0_a, 32'd0);
    chk("idle_data_1_a", d1_a, 32'd0);
    chk("idle_data_0_b", d0_b, 32'd0);
    chk("idle_data_1_b", d1_b, 32'd0);

    // Single ADD from requester 0: 5 + 7 = 12.
    set0(3'b000, F7B, 32'd5, 32'd7);
    step(2'b01, 1'b0, 2'b01, 1'b1, 32'd12, 1'b0);
    repeat (5) step(2'b00, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0);

    // From reset, both valid for four cycles: grants 0,1,0,1.
    do_reset();
    set0(3'b000, F7B, 32'd10, 32'd3);
    set1(3'b000, F7A, 32'd10, 32'd3);
    step(2'b11, 1'b0, 2'b01, 1'b1, 32'd13, 1'b0);
    step(2'b11, 1'b0, 2'b10, 1'b1, 32'd7, 1'b0);
    step(2'b11, 1'b0, 2'b01, 1'b1, 32'd13, 1'b0);
    step(2'b11, 1'b0, 2'b10, 1'b1, 32'd7, 1'b0);
    repeat (5) step(2'b00, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0);

    // Illegal alternate funct7 with funct3=001 from requester 1.
    set1(3'b001, F7A, 32'd1, 32'd2);
    step(2'b10, 1'b0, 2'b10, 1'b0, 32'd0, 1'b1);
    repeat (5) step(2'b00, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0);

    // Legal SRA (req 0 wins, rr_ptr=0), then SRL on req 1, then illegal MUL encoding.
    set0(3'b101, F7A, 32'h8000_0000, 32'd4);
    set1(3'b101, F7B, 32'h8000_0000, 32'd4);
    step(2'b11, 1'b0, 2'b01, 1'b1, 32'hF800_0000, 1'b0);
    step(2'b10, 1'b0, 2'b10, 1'b1, 32'h0800_0000, 1'b0);
    set0(3'b000, 7'b0000001, 32'd3, 32'd4);
    step(2'b01, 1'b0, 2'b01, 1'b0, 32'd0, 1'b1);
    repeat (5) step(2'b00, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0);

    // Two ops then flush with requester 0 still valid.
    set0(3'b000, F7B, 32'd1, 32'd1);
    step(2'b01, 1'b0, 2'b01, 1'b1, 32'd2, 1'b0);
    set1(3'b100, F7B, 32'h0000_00F0, 32'h0000_000F);
    step(2'b10, 1'b0, 2'b10, 1'b1, 32'h0000_00FF, 1'b0);
    step(2'b01, 1'b1, 2'b00, 1'b0, 32'd0, 1'b0);
    repeat (5) step(2'b00, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0);

    // Back-to-back stream (rr_ptr=0): grants 0,1,0,1,0,1,0 leave rr_ptr=1, then reset.
    set0(3'b000, F7B, 32'd100, 32'd23);
    set1(3'b000, F7A, 32'd100, 32'd23);
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) step(2'b11, 1'b0, 2'b01, 1'b1, 32'd123, 1'b0);
      else            step(2'b11, 1'b0, 2'b10, 1'b1, 32'd77, 1'b0);
    end
    do_reset();
    // rr_ptr back to 0: requester 0 wins contention.
    step(2'b11, 1'b0, 2'b01, 1'b1, 32'd123, 1'b0);
    repeat (6) step(2'b00, 1'b0, 2'b00, 1'b0, 32'd0, 1'b0);

    chk("queue_a_empty", qa.size(), 32'd0);
    chk("queue_b_empty", qb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
